// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker: locks onto an incrementing WIDTH-bit counter stream and
// flags every break in the sequence once locked.
// Latency: every output is registered and reflects the sample taken at the same edge.
// Backpressure: none; valid_in qualifies samples, and idle gaps of any length freeze all state.
//
// Ports:
//   clk, rst          sole clock; synchronous active-high reset
//   valid_in, cnt_in  sample strobe and counter value under test
//   locked            sequence lock held
//   err               one-cycle pulse per mismatch while locked
//   err_count         saturating mismatch tally
//   wrap_count        locked wrap-arounds through zero, modulo 2^ERRW
//   expected          next value the checker expects
module cnt_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 2,   // legal range 1..15
  parameter int ERRW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             locked,
  output logic             err,
  output logic [ERRW-1:0]  err_count,
  output logic [ERRW-1:0]  wrap_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_LEN);

  state_t           state;
  logic [3:0]       match_cnt;
  logic [WIDTH-1:0] cnt_plus1;
  logic [WIDTH-1:0] exp_plus1;
  logic [3:0]       match_inc;
  logic             hit;

  // Truncating increments: 2^WIDTH-1 is followed by 0.
  assign cnt_plus1 = cnt_in + 1'b1;
  assign exp_plus1 = expected + 1'b1;
  assign match_inc = match_cnt + 4'd1;
  assign hit       = (cnt_in == expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      match_cnt  <= 4'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      expected   <= '0;
    end else begin
      // err is a pulse: cleared on every edge unless a locked mismatch re-raises it.
      err <= 1'b0;
      if (valid_in) begin
        case (state)
          IDLE: begin
            expected  <= cnt_plus1;
            match_cnt <= 4'd0;
            state     <= ACQ;
          end
          ACQ: begin
            // Whether or not the sample matched, re-anchor on what was received.
            expected <= cnt_plus1;
            if (hit) begin
              match_cnt <= match_inc;
              if (match_inc == LOCK_TGT) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            if (hit) begin
              expected <= exp_plus1;
              if (cnt_in == '0) begin
                wrap_count <= wrap_count + 1'b1;
              end
            end else begin
              err       <= 1'b1;
              if (err_count != '1) begin
                err_count <= err_count + 1'b1;
              end
              locked    <= 1'b0;
              state     <= ACQ;
              match_cnt <= 4'd0;
              expected  <= cnt_plus1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb_cnt_seq_checker: randomized counter stream with jumps, idle gaps and
// resets, compared every cycle against a behavioural model.
// Two instances share the stimulus: ERRW=8 and ERRW=2 (exercises saturation).
module tb_cnt_seq_checker;

  localparam int WIDTH    = 4;
  localparam int LOCK_LEN = 2;
  localparam int MODV     = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [WIDTH-1:0] cnt_in;

  logic             locked_a, err_a;
  logic [7:0]       err_count_a, wrap_count_a;
  logic [WIDTH-1:0] expected_a;
  logic             locked_b, err_b;
  logic [1:0]       err_count_b, wrap_count_b;
  logic [WIDTH-1:0] expected_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, in plain integers.
  bit m_seen;     // a valid sample has arrived since reset
  bit m_locked;
  bit m_err;
  int m_run;      // consecutive correct samples while acquiring
  int m_exp;
  int m_errs;     // unbounded mismatch total
  int m_wraps;    // unbounded wrap total

  always #5 clk = ~clk;

  cnt_seq_checker #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERRW(8)) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .cnt_in(cnt_in),
    .locked(locked_a), .err(err_a), .err_count(err_count_a),
    .wrap_count(wrap_count_a), .expected(expected_a)
  );

  cnt_seq_checker #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERRW(2)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .cnt_in(cnt_in),
    .locked(locked_b), .err(err_b), .err_count(err_count_b),
    .wrap_count(wrap_count_b), .expected(expected_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, want);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_step(input bit r, input bit v, input int c);
    if (r) begin
      m_seen = 0; m_locked = 0; m_err = 0; m_run = 0;
      m_exp = 0; m_errs = 0; m_wraps = 0;
    end else begin
      m_err = 0;
      if (v) begin
        if (!m_seen) begin
          m_seen = 1;
          m_run  = 0;
          m_exp  = (c + 1) % MODV;
        end else if (!m_locked) begin
          m_run  = (c == m_exp) ? m_run + 1 : 0;
          m_exp  = (c + 1) % MODV;
          if (m_run == LOCK_LEN) m_locked = 1;
        end else if (c == m_exp) begin
          m_exp = (m_exp + 1) % MODV;
          if (c == 0) m_wraps++;
        end else begin
          m_err    = 1;
          m_errs++;
          m_locked = 0;
          m_run    = 0;
          m_exp    = (c + 1) % MODV;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("locked",       32'(locked_a),     32'(m_locked));
    check("err",          32'(err_a),        32'(m_err));
    check("expected",     32'(expected_a),   32'(m_exp));
    check("err_count",    32'(err_count_a),  32'(sat(m_errs, 255)));
    check("wrap_count",   32'(wrap_count_a), 32'(m_wraps % 256));
    check("locked_e2",    32'(locked_b),     32'(m_locked));
    check("err_e2",       32'(err_b),        32'(m_err));
    check("expected_e2",  32'(expected_b),   32'(m_exp));
    check("err_count_e2", 32'(err_count_b),  32'(sat(m_errs, 3)));
    check("wrap_count_e2",32'(wrap_count_b), 32'(m_wraps % 4));
  endtask

  // Apply one cycle of inputs, clock it, update the model, check after the edge.
  task automatic cycle(input bit r, input bit v, input int c);
    rst      = r;
    valid_in = v;
    cnt_in   = WIDTH'(c);
    @(posedge clk);
    model_step(r, v, c);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    int src;
    int rst_hold;
    bit v;
    int c;

    rst = 1'b1; valid_in = 1'b0; cnt_in = '0;
    src = 0; rst_hold = 0;
    @(negedge clk);

    // Reset with garbage on the inputs: everything must read zero.
    cycle(1'b1, 1'b1, 9);
    cycle(1'b1, 1'b1, 3);

    // Clean run from 0: lock after the sample of 2, then cross a wrap.
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, i % MODV);
    src = 20 % MODV;

    // Gap with random counter values: nothing may move.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, int'($urandom_range(0, MODV - 1)));

    // Randomized stream: mostly incrementing, occasional jumps, gaps and resets.
    for (int i = 0; i < 3000; i++) begin
      if (rst_hold == 0 && $urandom_range(0, 299) == 0) rst_hold = int'($urandom_range(1, 3));
      v = ($urandom_range(0, 7) != 0);
      if (rst_hold > 0) begin
        rst_hold--;
        c = int'($urandom_range(0, MODV - 1));
        cycle(1'b1, 1'b1, c);
      end else if (v) begin
        if ($urandom_range(0, 19) == 0) src = int'($urandom_range(0, MODV - 1));
        c = src;
        src = (src + 1) % MODV;
        cycle(1'b0, 1'b1, c);
      end else begin
        cycle(1'b0, 1'b0, int'($urandom_range(0, MODV - 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_seq_checker.md
# cnt_seq_checker

Consuming end of the free-running counter interface: samples a `WIDTH`-bit counter stream, acquires lock on an incrementing sequence and flags every break in it. It sits in the Verilator learning benches beside the counter source, with `cnt2` typically wired to `valid_in`. Its registered status (lock, error pulse, error and wrap tallies) is what the C++ harness checks, replacing eyeballed `$display` output.

## Interface
Parameters:
- `WIDTH`, 4: counter width; compare and increment are modulo 2^WIDTH.
- `LOCK_LEN`, 2: consecutive correct samples needed to lock; legal range 1..15.
- `ERRW`, 8: width of `err_count` and `wrap_count`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `valid_in`  in  1  `cnt_in` is meaningful this cycle.
- `cnt_in`  in  WIDTH  counter value under test.
- `locked`  out  1  sequence lock held.
- `err`  out  1  one-cycle pulse per mismatch while locked.
- `err_count`  out  ERRW  saturating mismatch tally.
- `wrap_count`  out  ERRW  locked wrap-arounds, modulo 2^ERRW.
- `expected`  out  WIDTH  next value the checker expects.

## Operation
- Reset state: all outputs 0, state IDLE, internal `match_cnt` 0.
- States:
  - IDLE: no valid sample seen since reset.
  - ACQ: synchronising.
  - LOCKED: tracking.
- IDLE, `valid_in`=1: `expected` <= `cnt_in`+1; `match_cnt` <= 0; go to ACQ.
- ACQ, `valid_in`=1, `cnt_in`==`expected`:
  - `match_cnt` increments.
  - When the new `match_cnt` equals `LOCK_LEN`: go to LOCKED, `locked` <= 1.
- ACQ, `valid_in`=1, mismatch: `match_cnt` <= 0; stay in ACQ; no `err`; `err_count` unchanged.
- ACQ, any valid sample: `expected` <= `cnt_in`+1.
- LOCKED, match:
  - `expected` <= `expected`+1.
  - If `cnt_in`==0, `wrap_count` increments, wrapping modulo 2^ERRW.
- LOCKED, mismatch:
  - `err` <= 1 for exactly one cycle.
  - `err_count` increments, saturating at 2^ERRW-1.
  - `locked` <= 0; go to ACQ; `match_cnt` <= 0.
  - `expected` <= `cnt_in`+1 (resync on the received value).
- `valid_in`=0, any state: no state or counter change; `expected` does not advance; `err` returns to 0. Gaps of any length are legal.
- A source reset forcing `cnt_in` to 0 while locked counts as an ordinary mismatch.
- `rst` dominates `valid_in` and every other event.
  - Asserting `rst` mid-operation returns everything to reset values on that edge.
  - Inputs are ignored while `rst` is high.
- Arithmetic: `cnt_in`+1 and `expected`+1 are truncated to WIDTH bits, so 2^WIDTH-1 is followed by 0.

## Timing
- Single clock domain. All outputs are registered; no combinational input-to-output path.
- Latency: a sample at edge N is reflected in `locked`, `err`, `expected`, `err_count` and `wrap_count` immediately after edge N.
- Lock latency for an unbroken stream: `locked` rises after edge LOCK_LEN, counting the first valid sample as edge 0. That is LOCK_LEN+1 valid samples.
- `err` width: exactly one cycle per mismatch, even with back-to-back invalid cycles afterwards.
- A second error cannot occur until lock is regained, so there are at least LOCK_LEN+1 valid samples between pulses.
- `rst` is sampled on the edge: `rst` high at edge N gives reset values after edge N. The first sample is accepted at the first edge with `rst`=0.

## Test plan
- Reset, then `cnt_in` = 0,1,2,3… with `valid_in`=1 and LOCK_LEN=2 -> `locked` rises after the edge sampling 2; `expected`=3 then; `err` stays 0.
- Locked with WIDTH=4; feed 14,15,0,1 -> `wrap_count` goes 0->1 after the edge sampling 0; `expected`=2 at the end; no `err`.
- Locked with `expected`=6; feed 9 -> one-cycle `err`, `err_count`=1, `locked`=0, `expected`=10. Then feed 10,11 -> `locked` again after the edge sampling 11.
- Locked with `expected`=5; `valid_in`=0 for 5 cycles with random `cnt_in`, then resume at 5 -> no state change during the gap; `expected`=6 after resume; `err`=0 throughout.
- ERRW=2; force 5 locked mismatches, relocking between each -> `err` pulses 5 times; `err_count` reads 1,2,3,3,3.
- Locked with counts nonzero; `rst`=1 for 2 cycles with `valid_in`=1 and changing `cnt_in` -> all outputs 0 after the first `rst` edge; the first sample after release sends the checker to ACQ.
